// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT sample framer.
// Combinational definitions only. No handshake of its own.
// The framer, its interface and the scaler import this package.
package fft_pkg;

    localparam int FFT_N = 16;
    localparam int T_W   = 18;
    localparam int T_MAX = 511;
    localparam int T_MIN = -512;

    typedef logic signed [T_W-1:0] t_sample_t;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} framer_state_t;

endpackage

// File: rtl/fft_sample_framer_if.sv
// Codec-sample and FFT-processor signals bundled for the framer.
// Wires only, so it adds no latency.
// There is no backpressure: sample_valid is never stalled.
interface fft_sample_framer_if #(
    parameter int IN_W = 24
);
    import fft_pkg::*;

    logic                     sample_valid;
    logic signed [IN_W-1:0]   sample_in;
    logic                     fft_done;
    logic                     new_t;
    logic [FFT_N*T_W-1:0]     t_bus;
    logic                     overrun;
    logic                     busy;

    modport master (
        output sample_valid, sample_in, fft_done,
        input  new_t, t_bus, overrun, busy
    );

    modport slave (
        input  sample_valid, sample_in, fft_done,
        output new_t, t_bus, overrun, busy
    );

endinterface

// File: rtl/fft_sample_framer_scaler.sv
// Shifts a signed sample right arithmetically, saturates it to [T_MIN, T_MAX] and sign-extends it to T_W bits.
// Purely combinational, with zero latency.
// Has no handshake and so applies no backpressure.
module sample_scaler
    import fft_pkg::*;
#(
    parameter int IN_W  = 24,
    parameter int SHIFT = 12
) (
    input  logic signed [IN_W-1:0] din,
    output t_sample_t              dout
);

    localparam logic signed [IN_W-1:0] S_MAX = IN_W'(T_MAX);
    localparam logic signed [IN_W-1:0] S_MIN = IN_W'(T_MIN);

    logic signed [IN_W-1:0] shifted;

    assign shifted = din >>> SHIFT;

    always_comb begin
        dout = T_W'(shifted);
        if (shifted > S_MAX) begin
            dout = T_W'(T_MAX);
        end else if (shifted < S_MIN) begin
            dout = T_W'(T_MIN);
        end
    end

endmodule

// File: rtl/fft_sample_framer.sv
// Frames scaled audio samples into 16-sample blocks for the FFT (new_t/done); FRAMER_OVERLAP_EN gives 50% overlap.
// Latency: new_t rises one clock after the completing sample when idle, or one clock after done if a frame is pending.
// Backpressure: none toward the codec; a frame that completes while one is already pending is dropped and overrun pulses.
module fft_sample_framer
    import fft_pkg::*;
#(
    parameter int IN_W  = 24,
    parameter int SHIFT = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    fft_sample_framer_if.slave    bus
);

`ifdef FRAMER_OVERLAP_EN
    localparam logic [3:0] CNT_RELOAD = 4'd8;
`else
    localparam logic [3:0] CNT_RELOAD = 4'd0;
`endif

    t_sample_t            scaled;
    t_sample_t            sr      [FFT_N];
    t_sample_t            sr_next [FFT_N];
    t_sample_t            pend    [FFT_N];
    logic                 pend_vld;
    logic [3:0]           cnt;
    framer_state_t        state;
    logic                 new_t_q;
    logic                 busy_q;
    logic                 overrun_q;
    logic [FFT_N*T_W-1:0] t_bus_q;
    logic                 frame_done;
    logic                 consume;

    sample_scaler #(
        .IN_W  (IN_W),
        .SHIFT (SHIFT)
    ) u_scaler (
        .din  (bus.sample_in),
        .dout (scaled)
    );

    // The pending copy must include the sample accepted on the completing edge.
    always_comb begin
        for (int k = 0; k < FFT_N - 1; k++) begin
            sr_next[k] = sr[k+1];
        end
        sr_next[FFT_N-1] = scaled;
    end

    assign frame_done = bus.sample_valid && (cnt == 4'(FFT_N - 1));
    assign consume    = (state == IDLE) && pend_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            pend_vld  <= 1'b0;
            new_t_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            t_bus_q   <= '0;
            for (int k = 0; k < FFT_N; k++) begin
                sr[k]   <= '0;
                pend[k] <= '0;
            end
        end else begin
            overrun_q <= frame_done && pend_vld && !consume;

            if (bus.sample_valid) begin
                sr  <= sr_next;
                cnt <= frame_done ? CNT_RELOAD : cnt + 4'd1;
            end

            // Pending being consumed this edge frees the slot for a frame completing now.
            if (frame_done && (!pend_vld || consume)) begin
                pend     <= sr_next;
                pend_vld <= 1'b1;
            end else if (consume) begin
                pend_vld <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pend_vld) begin
                        state   <= ISSUE;
                        new_t_q <= 1'b1;
                        busy_q  <= 1'b1;
                        for (int k = 0; k < FFT_N; k++) begin
                            t_bus_q[k*T_W +: T_W] <= pend[k];
                        end
                    end
                end
                ISSUE: begin
                    state   <= BUSY;
                    new_t_q <= 1'b0;
                end
                BUSY: begin
                    if (bus.fft_done) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.new_t   = new_t_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;
    assign bus.t_bus   = t_bus_q;

endmodule

// File: tb/tb_fft_sample_framer.sv
// Directed bench for fft_sample_framer: issued frames are queued with their expected new_t cycle,
// and a negedge monitor pops and compares them while also watching t_bus stability and overrun pulses.
module tb_fft_sample_framer;
    import fft_pkg::*;

    typedef struct {
        logic [FFT_N*T_W-1:0] frame;
        int                   when;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   ovr_cnt = 0;
    int   base;
    int   vals [FFT_N];
    exp_t expq [$];
    exp_t mon_e;
    exp_t push_e;
    logic [FFT_N*T_W-1:0] prev_tbus = '0;

    fft_sample_framer_if #(.IN_W(24)) bus();

    fft_sample_framer #(
        .IN_W  (24),
        .SHIFT (12)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [FFT_N*T_W-1:0] pack(input int v [FFT_N]);
        logic [FFT_N*T_W-1:0] r;
        r = '0;
        for (int k = 0; k < FFT_N; k++) r[k*T_W +: T_W] = T_W'(v[k]);
        return r;
    endfunction

    task automatic check(input string name, input logic [FFT_N*T_W-1:0] act, input logic [FFT_N*T_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [23:0] v);
        bus.sample_valid = 1'b1;
        bus.sample_in    = v;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_done();
        bus.fft_done = 1'b1;
        @(posedge clk); #1;
        bus.fft_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic expect_frame(input int when);
        push_e.frame = pack(vals);
        push_e.when  = when;
        expq.push_back(push_e);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_tbus = bus.t_bus;
        end else begin
            if (bus.overrun) ovr_cnt++;
            if (bus.new_t) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_new_t: new_t high at cycle %0d with no frame expected", cyc);
                end else begin
                    mon_e = expq.pop_front();
                    check("frame", bus.t_bus, mon_e.frame);
                    check("new_t_cycle", cyc, mon_e.when);
                end
            end else begin
                check("t_bus_stable", bus.t_bus, prev_tbus);
            end
            prev_tbus = bus.t_bus;
        end
    end

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        bus.fft_done     = 1'b0;

        // Reset state
        #1 reset = 1'b1;
        #2;
        check("rst_new_t", bus.new_t, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_overrun", bus.overrun, 1'b0);
        check("rst_t_bus", bus.t_bus, '0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Ramp: t_k = k
        for (int k = 0; k < FFT_N; k++) begin
            vals[k] = k;
            send(24'(k * 'h1000));
        end
        expect_frame(cyc + 1);
        idle(2);
        check("ramp_busy", bus.busy, 1'b1);
        check("ramp_new_t_low", bus.new_t, 1'b0);
        pulse_done();
        check("ramp_busy_clear", bus.busy, 1'b0);

        // Saturation, then done during ISSUE is ignored
        do_reset();
        for (int k = 0; k < 12; k++) begin
            vals[k] = 100 + k;
            send(24'((100 + k) * 'h1000));
        end
        vals[12] = 511;
        vals[13] = -512;
        vals[14] = -1;
        vals[15] = 1;
        send(24'h7FFFFF);
        send(24'h800000);
        send(24'hFFF000);
        send(24'h001000);
        expect_frame(cyc + 1);
        idle(1);
        bus.fft_done = 1'b1;
        idle(1);
        bus.fft_done = 1'b0;
        check("early_done_busy", bus.busy, 1'b1);
        idle(2);
        check("early_done_busy_later", bus.busy, 1'b1);
        pulse_done();
        check("late_done_busy", bus.busy, 1'b0);

`ifndef FRAMER_OVERLAP_EN
        // Overrun: frame 1 issued, frame 2 pending, frame 3 dropped
        do_reset();
        base = ovr_cnt;
        for (int n = 0; n < 48; n++) begin
            send(24'(n * 'h1000));
            if (n == 15) begin
                for (int k = 0; k < FFT_N; k++) vals[k] = k;
                expect_frame(cyc + 1);
            end
        end
        check("overrun_pulse", bus.overrun, 1'b1);
        idle(1);
        check("overrun_single", bus.overrun, 1'b0);
        check("overrun_count", ovr_cnt - base, 1);
        for (int k = 0; k < FFT_N; k++) vals[k] = k;
        check("t_bus_held", bus.t_bus, pack(vals));
        check("overrun_busy", bus.busy, 1'b1);
        for (int k = 0; k < FFT_N; k++) vals[k] = 16 + k;
        expect_frame(cyc + 2);
        pulse_done();
        idle(3);
        pulse_done();
        check("overrun_busy_clear", bus.busy, 1'b0);
`endif

        // Reset while BUSY with 7 samples collected
        do_reset();
        for (int k = 0; k < FFT_N; k++) begin
            vals[k] = 300 + k;
            send(24'((300 + k) * 'h1000));
        end
        expect_frame(cyc + 1);
        idle(2);
        for (int k = 0; k < 7; k++) send(24'h7FF000);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_new_t", bus.new_t, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_overrun", bus.overrun, 1'b0);
        check("mid_rst_t_bus", bus.t_bus, '0);
        idle(1);
        reset = 1'b0;
        for (int k = 0; k < 9; k++) begin
            vals[k] = 400 + k;
            send(24'((400 + k) * 'h1000));
        end
        idle(3);
        check("fresh_no_frame", bus.busy, 1'b0);
        for (int k = 9; k < FFT_N; k++) begin
            vals[k] = 400 + k;
            send(24'((400 + k) * 'h1000));
        end
        expect_frame(cyc + 1);
        idle(2);
        check("fresh_busy", bus.busy, 1'b1);
        pulse_done();

`ifdef FRAMER_OVERLAP_EN
        // Overlap: frames after samples 16, 24 and 32 with done held high
        do_reset();
        bus.fft_done = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            send(24'(n * 'h1000));
            if (n == 16 || n == 24 || n == 32) begin
                for (int k = 0; k < FFT_N; k++) vals[k] = n - 15 + k;
                expect_frame(cyc + 1);
            end
        end
        idle(3);
        bus.fft_done = 1'b0;
        check("overlap_busy_clear", bus.busy, 1'b0);
`endif

        idle(4);
        check("queue_empty", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
